// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbiter and registered selector with a
// valid/ready handshake on every input and on the single output.
// Optional feature macro: ARB_LOCK_EN adds the in_lock port. With it, a
// channel can keep ownership of the arbiter across several words.

module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_grant
`ifdef ARB_LOCK_EN
  ,
  input  logic [N-1:0]       in_lock
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_grant_q, out_grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic             load_en;
  logic [N-1:0]     eligible;
  logic [N-1:0]     grant_next;
  logic             found;
  logic [PW-1:0]    win_idx;
  logic [WIDTH-1:0] sel_data;

`ifdef ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [PW-1:0]    owner_q, owner_d;
`endif

  // The output register can take a new word when it is empty or being popped.
  assign load_en = !out_valid_q || out_ready;

  // Requests allowed to compete this cycle; a held lock admits only its owner.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
`ifdef ARB_LOCK_EN
      eligible[i] = in_valid[i] && (!lock_q || (owner_q == PW'(i)));
`else
      eligible[i] = in_valid[i];
`endif
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin : arb_search
    int idx;
    logic [PW-1:0] idx_w;
    idx        = 0;
    idx_w      = '0;
    grant_next = '0;
    win_idx    = '0;
    found      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(ptr_q) + k) % N;
      idx_w = PW'(idx);
      if (!found && eligible[idx_w]) begin
        found             = 1'b1;
        win_idx           = idx_w;
        grant_next[idx_w] = 1'b1;
      end
    end
  end

  // One-hot mux of the winning channel's data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_next[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = load_en ? grant_next : '0;

  // Next-state for the output stage, the priority pointer and the lock.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_grant_d = out_grant_q;
    ptr_d       = ptr_q;
`ifdef ARB_LOCK_EN
    lock_d      = lock_q;
    owner_d     = owner_q;
`endif
    if (load_en) begin
      if (found) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
        out_grant_d = grant_next;
        ptr_d       = win_idx;
`ifdef ARB_LOCK_EN
        if (in_lock[win_idx]) begin
          lock_d  = 1'b1;
          owner_d = win_idx;
        end else begin
          lock_d  = 1'b0;
        end
`endif
      end else begin
        out_valid_d = 1'b0;
        out_grant_d = '0;
      end
    end
  end

  // State registers; the pointer resets to N-1 so channel 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_grant_q <= '0;
      ptr_q       <= PW'(N - 1);
`ifdef ARB_LOCK_EN
      lock_q      <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_grant_q <= out_grant_d;
      ptr_q       <= ptr_d;
`ifdef ARB_LOCK_EN
      lock_q      <= lock_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: scoreboard bench for rr_arb_mux (N=5, WIDTH=32).
// Compile with ARB_LOCK_EN defined to also exercise the lock feature.

module tb_rr_arb_mux;

  localparam int N     = 5;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [N-1:0]     grant;
  } sbEntry_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [N-1:0]       out_grant;
  logic [N-1:0]       in_lock = '0;

  logic [WIDTH-1:0]   chData [N];
  sbEntry_t           sbQueue [$];
  int                 compared = 0;
  int                 mismatched = 0;

  int                 mPtr = N - 1;
  bit                 mValid = 1'b0;
  logic [WIDTH-1:0]   mLast = '0;
  bit                 mLock = 1'b0;
  int                 mOwner = 0;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant)
`ifdef ARB_LOCK_EN
    ,
    .in_lock   (in_lock)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    sbQueue.delete();
    mPtr   = N - 1;
    mValid = 1'b0;
    mLast  = '0;
    mLock  = 1'b0;
    mOwner = 0;
  endtask

  // Drive one cycle at the falling edge, check the registered outputs and
  // in_ready, then advance the reference model across the next rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic r, input logic [N-1:0] lk);
    sbEntry_t exp;
    logic [N-1:0] expReady;
    bit loadEn;
    int w;
    @(negedge clk);
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chData[i];
    in_valid  = v;
    out_ready = r;
    in_lock   = lk;
    #1;
    checkOutput("out_valid", out_valid, mValid);
    if (mValid) begin
      exp = '0;
      if (sbQueue.size() > 0) exp = sbQueue[0];
      checkOutput("out_data", out_data, exp.data);
      checkOutput("out_grant", out_grant, exp.grant);
      if (r) void'(sbQueue.pop_front());
    end else begin
      checkOutput("idle_data", out_data, mLast);
      checkOutput("idle_grant", out_grant, '0);
    end
    loadEn = !mValid || r;
    w = -1;
    for (int off = 1; off <= N; off++) begin
      int c;
      bit ok;
      c  = (mPtr + off) % N;
      ok = v[c];
`ifdef ARB_LOCK_EN
      if (mLock && c != mOwner) ok = 1'b0;
`endif
      if (w < 0 && ok) w = c;
    end
    expReady = '0;
    if (loadEn && w >= 0) expReady[w] = 1'b1;
    checkOutput("in_ready", in_ready, expReady);
    if (loadEn) begin
      if (w >= 0) begin
        exp.data  = chData[w];
        exp.grant = expReady;
        sbQueue.push_back(exp);
        mLast  = chData[w];
        mPtr   = w;
        mValid = 1'b1;
`ifdef ARB_LOCK_EN
        if (lk[w]) begin
          mLock  = 1'b1;
          mOwner = w;
        end else begin
          mLock  = 1'b0;
        end
`endif
      end else begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = '0;
    clearModel();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Assert reset between edges and confirm the output drops immediately.
  task automatic midReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", out_valid, 1'b0);
    checkOutput("async_grant", out_grant, '0);
    in_valid = '0;
    clearModel();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) chData[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset idle");
    repeat (3) applyStimulus('0, 1'b1, '0);

    $display("[TB] single request on channel 2");
    chData[2] = 32'hCAFE0002;
    applyStimulus(5'b00100, 1'b1, '0);
    repeat (2) applyStimulus('0, 1'b1, '0);

    $display("[TB] all channels valid, full throughput");
    doReset();
    for (int i = 0; i < N; i++) chData[i] = 32'h100 + i;
    repeat (10) applyStimulus('1, 1'b1, '0);
    repeat (2) applyStimulus('0, 1'b1, '0);

    $display("[TB] backpressure");
    doReset();
    repeat (2) applyStimulus('1, 1'b1, '0);
    repeat (3) applyStimulus('1, 1'b0, '0);
    repeat (3) applyStimulus('1, 1'b1, '0);
    repeat (2) applyStimulus('0, 1'b1, '0);

    $display("[TB] asynchronous reset mid-stream");
    repeat (3) applyStimulus('1, 1'b1, '0);
    midReset();
    applyStimulus('1, 1'b1, '0);
    repeat (2) applyStimulus('0, 1'b1, '0);

`ifdef ARB_LOCK_EN
    $display("[TB] channel lock");
    doReset();
    for (int i = 0; i < N; i++) chData[i] = 32'h200 + i;
    applyStimulus(5'b01000, 1'b1, 5'b01000);
    applyStimulus('1, 1'b1, 5'b01000);
    applyStimulus('1, 1'b1, 5'b00000);
    applyStimulus('1, 1'b1, 5'b00000);
    repeat (2) applyStimulus('0, 1'b1, '0);
`endif

    $display("[TB] random traffic");
    doReset();
    for (int n = 0; n < 200; n++) begin
      logic [N-1:0] v;
      logic [N-1:0] lk;
      logic r;
      for (int i = 0; i < N; i++) chData[i] = $urandom;
      v  = N'($urandom);
      r  = ($urandom_range(0, 3) != 0);
      lk = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      applyStimulus(v, r, lk);
    end
    repeat (3) applyStimulus('0, 1'b1, '0);
    checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
